buffered_half_duplex_uart: RTL
==============================

BUFFERED_HALF_DUPLEX_UART -- requirements
Module: buffered_half_duplex_uart

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, character width (5..9).
REQ-002 SHALL have parameter CLOCK_PER_BIT_WIDTH, default 13, width of clocksPerBit.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per TX and per RX FIFO (power of 2, >=2).
REQ-004 SHALL have ports, clock and reset first; one clock, synchronous active-high reset:
  clk  in  1  sole clock, all logic on rising edge
  reset  in  1  synchronous, active-high
  serialIn  in  1  line input, idle high
  serialOut  out  1  line output, 1 when not driving
  isTx  out  1  1 while block drives the line
  clocksPerBit  in  CLOCK_PER_BIT_WIDTH  clk cycles per bit (etu), >=4
  stopBit2  in  1  0: one stop bit, 1: two
  oddParity  in  1  1: data+parity has odd count of ones
  msbFirst  in  1  1: data bits MSB first
  txData  in  DATA_BITS  character to queue
  txWrite  in  1  push txData when txFull=0
  txFull / txEmpty  out  1  TX FIFO status
  rxData  out  DATA_BITS  RX FIFO head, valid when rxEmpty=0
  rxRead  in  1  pop RX head when rxEmpty=0
  rxEmpty  out  1  RX FIFO status
  overrunErrorFlag  out  1  sticky: character dropped, RX FIFO full
  frameErrorFlag  out  1  sticky: bad parity or stop bit
  ackFlags  in  1  clears both sticky flags
  endOfRx  out  1  one-cycle pulse, last cycle of last RX stop bit
  rxRun / txRun  out  1  FSM in RX / TX states

Function
REQ-005 SHALL use one FSM: IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, TX_START, TX_DATA, TX_PARITY, TX_STOP (plus ERR_SIG per REQ-021).
REQ-006 SHALL time each bit with a counter from 0 to clocksPerBit-1; RX samples at count clocksPerBit/2 (floor).
REQ-007 IDLE -> RX_START on serialIn=0; at midpoint, serialIn=1 -> IDLE (glitch, no flag), else RX_DATA.
REQ-008 RX has priority: IDLE enters TX_START only when TX FIFO non-empty and serialIn=1 that cycle.
REQ-009 TX pops FIFO head on entering TX_START; frame = start(0), DATA_BITS data, parity, 1 or 2 stop(1), each exactly clocksPerBit cycles.
REQ-010 isTx SHALL be 1 from TX_START through TX_PARITY, 0 during TX_STOP (line released, serialOut=1).
REQ-011 Data order: LSB first when msbFirst=0, MSB first when 1; RX stores in natural bit order.
REQ-012 Parity bit = XOR(data) XOR oddParity; RX check uses same rule.
REQ-013 At end of last RX stop bit: endOfRx pulses; good character pushed to RX FIFO; parity or stop mismatch sets frameErrorFlag and drops character.
REQ-014 Good character with RX FIFO full (after a same-cycle rxRead) SHALL be dropped and set overrunErrorFlag.
REQ-015 rxRead and push in same cycle SHALL both take effect; txWrite when full and rxRead when empty SHALL be ignored.
REQ-016 Flag set and ackFlags in same cycle: set wins.
REQ-017 stopBit2, oddParity, msbFirst, clocksPerBit sampled only in IDLE; changes mid-frame no effect.
REQ-018 Back-to-back TX: queued character starts the cycle after TX_STOP ends (no extra idle).

Reset
REQ-019 reset SHALL abort any frame, empty both FIFOs, FSM -> IDLE; outputs: serialOut=1, isTx=0, txEmpty=1, txFull=0, rxEmpty=1, flags=0, endOfRx=0, rxRun=0, txRun=0, rxData=0.
REQ-020 Reset mid-TX SHALL release the line within the reset cycle's next edge.

Configuration
REQ-021 With ISO_ERROR_SIGNAL_EN defined: RX parity error -> ERR_SIG at midpoint of first stop bit, serialOut=0, isTx=1 for clocksPerBit cycles, then one released bit time, then IDLE; character dropped, frameErrorFlag set, endOfRx pulses at end of ERR_SIG. Without it: no ERR_SIG state, line never driven during RX.

Structure
REQ-022 Shared package uart_pkg SHALL hold the state enumeration and parity/bit-order helper constants.
REQ-023 Sub-module sync_fifo (DATA_BITS x FIFO_DEPTH, full/empty) SHALL be instantiated twice, TX and RX.

Verification
REQ-024 clocksPerBit=16, 8N even parity, txWrite 0xA5 -> serialOut 0,1,0,1,0,0,1,0,1,0(parity),1; isTx low in stop bit; 176 cycles.
REQ-025 RX 0x3C, correct parity, msbFirst=1 -> rxData=0x3C, rxEmpty=0, endOfRx one pulse, no flags.
REQ-026 4-cycle low glitch, clocksPerBit=16 -> FSM returns IDLE, no push, no flags.
REQ-027 FIFO_DEPTH=4, 5 characters received, no reads -> first 4 kept in order, overrunErrorFlag=1; ackFlags clears it.
REQ-028 Bad parity with ISO_ERROR_SIGNAL_EN -> serialOut low 16 cycles from stop-bit midpoint, frameErrorFlag=1; without macro line stays high.
REQ-029 Reset asserted mid-TX data bit -> serialOut=1, isTx=0, txEmpty=1 next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered half-duplex UART: FSM state codes
// and the encodings used for the parity and bit-order configuration inputs.
package uart_pkg;

   typedef logic [3:0] state_t;

   // state        | meaning
   // IDLE         | line released, waiting for a start bit or a queued character
   // RX_START     | receiving start bit, glitch check at midpoint
   // RX_DATA      | receiving data bits
   // RX_PARITY    | receiving parity bit
   // RX_STOP      | receiving one or two stop bits
   // TX_START     | driving start bit (0)
   // TX_DATA      | driving data bits
   // TX_PARITY    | driving parity bit
   // TX_STOP      | line released for one or two stop bit times
   // ERR_SIG      | parity error signal: one bit driven low, one bit released
   localparam state_t ST_IDLE      = 4'd0;
   localparam state_t ST_RX_START  = 4'd1;
   localparam state_t ST_RX_DATA   = 4'd2;
   localparam state_t ST_RX_PARITY = 4'd3;
   localparam state_t ST_RX_STOP   = 4'd4;
   localparam state_t ST_TX_START  = 4'd5;
   localparam state_t ST_TX_DATA   = 4'd6;
   localparam state_t ST_TX_PARITY = 4'd7;
   localparam state_t ST_TX_STOP   = 4'd8;
   localparam state_t ST_ERR_SIG   = 4'd9;

   // Parity bit = XOR(data) XOR oddParity.
   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // msbFirst encoding.
   localparam logic ORDER_LSB_FIRST = 1'b0;
   localparam logic ORDER_MSB_FIRST = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty status. A read and a write in the same
// cycle both take effect, including a write while full when the read frees
// a slot. Reads while empty and writes with no room are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_rd;
   logic             w_do_wr;

   assign full    = (r_count == (AW+1)'(DEPTH));
   assign empty   = (r_count == '0);
   assign w_do_rd = rd_en && !empty;
   assign w_do_wr = wr_en && (!full || w_do_rd);
   // Head reads as zero while empty so the output is clean after reset.
   assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

   // Storage array, written on accepted pushes.
   always_ff @(posedge clk) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/buffered_half_duplex_uart.sv
// Half-duplex UART on a single shared line with TX and RX FIFOs.
// One FSM handles both directions; reception has priority over transmission.
// Optional build macro ISO_ERROR_SIGNAL_EN: on an RX parity error the block
// drives the line low for one bit time from the first stop-bit midpoint.
module buffered_half_duplex_uart
   import uart_pkg::*;
#(
   parameter int DATA_BITS           = 8,
   parameter int CLOCK_PER_BIT_WIDTH = 13,
   parameter int FIFO_DEPTH          = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           serialIn,
   output logic                           serialOut,
   output logic                           isTx,
   input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
   input  logic                           stopBit2,
   input  logic                           oddParity,
   input  logic                           msbFirst,
   input  logic [DATA_BITS-1:0]           txData,
   input  logic                           txWrite,
   output logic                           txFull,
   output logic                           txEmpty,
   output logic [DATA_BITS-1:0]           rxData,
   input  logic                           rxRead,
   output logic                           rxEmpty,
   output logic                           overrunErrorFlag,
   output logic                           frameErrorFlag,
   input  logic                           ackFlags,
   output logic                           endOfRx,
   output logic                           rxRun,
   output logic                           txRun
);

   localparam int CW = CLOCK_PER_BIT_WIDTH;
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        r_cpb;
   logic [BW-1:0]        r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic                 r_perr;
   logic                 r_serr;
   logic                 r_phase;
   logic                 r_stop2;
   logic                 r_odd;
   logic                 r_msb;
   logic                 r_serial_out;
   logic                 r_is_tx;
   logic                 r_ovr;
   logic                 r_ferr;

   logic [DATA_BITS-1:0] w_tx_head;
   logic                 w_tx_empty;
   logic                 w_tx_full;
   logic                 w_rx_full;
   logic                 w_rx_empty;
   logic                 w_half_hit;
   logic                 w_bit_end;
   logic                 w_last_bit;
   logic                 w_tx_cur;
   logic                 w_tx_next;
   logic                 w_rx_done;
   logic                 w_rx_good;
   logic                 w_rx_space;
   logic                 w_rx_push;
   logic                 w_set_ovr;
   logic                 w_set_ferr;
   logic                 w_errsig_done;
   logic                 w_tx_stop_done;
   logic                 w_launch;
   logic                 w_tx_pop;

   assign w_half_hit = (r_cnt == (r_cpb >> 1));
   assign w_bit_end  = (r_cnt == (r_cpb - CNT_ONE));
   assign w_last_bit = (r_bit_idx == LAST_BIT);
   assign w_tx_cur   = (r_msb == ORDER_MSB_FIRST) ? r_shift[DATA_BITS-1] : r_shift[0];
   assign w_tx_next  = (r_msb == ORDER_MSB_FIRST) ? r_shift[DATA_BITS-2] : r_shift[1];

   assign w_rx_done  = (r_state == ST_RX_STOP) && w_bit_end && (r_phase || !r_stop2);
   assign w_rx_good  = !r_perr && !r_serr;
   // A same-cycle read frees the slot the incoming character needs.
   assign w_rx_space = !w_rx_full || rxRead;
   assign w_rx_push  = w_rx_done && w_rx_good && w_rx_space;
   assign w_set_ovr  = w_rx_done && w_rx_good && !w_rx_space;

`ifdef ISO_ERROR_SIGNAL_EN
   assign w_errsig_done = (r_state == ST_ERR_SIG) && w_bit_end && r_phase;
   assign rxRun = (r_state inside {ST_RX_START, ST_RX_DATA, ST_RX_PARITY, ST_RX_STOP, ST_ERR_SIG});
`else
   assign w_errsig_done = 1'b0;
   assign rxRun = (r_state inside {ST_RX_START, ST_RX_DATA, ST_RX_PARITY, ST_RX_STOP});
`endif
   assign txRun = (r_state inside {ST_TX_START, ST_TX_DATA, ST_TX_PARITY, ST_TX_STOP});

   assign w_set_ferr = (w_rx_done && !w_rx_good) || w_errsig_done;
   assign endOfRx    = w_rx_done || w_errsig_done;

   // A frame may start from IDLE or straight out of the last TX stop bit,
   // which gives back-to-back transmission without an idle cycle.
   assign w_tx_stop_done = (r_state == ST_TX_STOP) && w_bit_end && (r_phase || !r_stop2);
   assign w_launch       = (r_state == ST_IDLE) || w_tx_stop_done;
   assign w_tx_pop       = w_launch && serialIn && !w_tx_empty;

   assign serialOut        = r_serial_out;
   assign isTx             = r_is_tx;
   assign txFull           = w_tx_full;
   assign txEmpty          = w_tx_empty;
   assign rxEmpty          = w_rx_empty;
   assign overrunErrorFlag = r_ovr;
   assign frameErrorFlag   = r_ferr;

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (txWrite),
      .wr_data (txData),
      .rd_en   (w_tx_pop),
      .rd_data (w_tx_head),
      .full    (w_tx_full),
      .empty   (w_tx_empty)
   );

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (w_rx_push),
      .wr_data (r_shift),
      .rd_en   (rxRead),
      .rd_data (rxData),
      .full    (w_rx_full),
      .empty   (w_rx_empty)
   );

   // Sticky error flags; a set in the same cycle as ackFlags wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovr  <= 1'b0;
         r_ferr <= 1'b0;
      end else begin
         r_ovr  <= w_set_ovr  || (r_ovr  && !ackFlags);
         r_ferr <= w_set_ferr || (r_ferr && !ackFlags);
      end
   end

   // Frame sequencer: bit timing, shifting, line drive and state transitions.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_cpb        <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_par        <= 1'b0;
         r_perr       <= 1'b0;
         r_serr       <= 1'b0;
         r_phase      <= 1'b0;
         r_stop2      <= 1'b0;
         r_odd        <= 1'b0;
         r_msb        <= 1'b0;
         r_serial_out <= 1'b1;
         r_is_tx      <= 1'b0;
      end else begin
         r_cnt <= r_cnt + CNT_ONE;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
            end
            ST_RX_START: begin
               if (w_half_hit && serialIn) begin
                  r_state <= ST_IDLE;
               end else if (w_bit_end) begin
                  r_state   <= ST_RX_DATA;
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_par     <= 1'b0;
               end
            end
            ST_RX_DATA: begin
               if (w_half_hit) begin
                  r_par <= r_par ^ serialIn;
                  if (r_msb == ORDER_MSB_FIRST)
                     r_shift <= {r_shift[DATA_BITS-2:0], serialIn};
                  else
                     r_shift <= {serialIn, r_shift[DATA_BITS-1:1]};
               end
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (w_last_bit) r_state <= ST_RX_PARITY;
                  else            r_bit_idx <= r_bit_idx + 1'b1;
               end
            end
            ST_RX_PARITY: begin
               if (w_half_hit) r_perr <= (serialIn != (r_par ^ r_odd));
               if (w_bit_end) begin
                  r_state <= ST_RX_STOP;
                  r_cnt   <= '0;
                  r_phase <= 1'b0;
                  r_serr  <= 1'b0;
               end
            end
            ST_RX_STOP: begin
               if (w_half_hit) begin
                  if (!serialIn) r_serr <= 1'b1;
`ifdef ISO_ERROR_SIGNAL_EN
                  if (!r_phase && r_perr) begin
                     r_state      <= ST_ERR_SIG;
                     r_cnt        <= '0;
                     r_serial_out <= 1'b0;
                     r_is_tx      <= 1'b1;
                  end
`endif
               end
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (!r_phase && r_stop2) r_phase <= 1'b1;
                  else                     r_state <= ST_IDLE;
               end
            end
            ST_TX_START: begin
               if (w_bit_end) begin
                  r_state      <= ST_TX_DATA;
                  r_cnt        <= '0;
                  r_bit_idx    <= '0;
                  r_serial_out <= w_tx_cur;
               end
            end
            ST_TX_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_msb == ORDER_MSB_FIRST) r_shift <= r_shift << 1;
                  else                          r_shift <= r_shift >> 1;
                  if (w_last_bit) begin
                     r_state      <= ST_TX_PARITY;
                     r_serial_out <= r_par;
                  end else begin
                     r_bit_idx    <= r_bit_idx + 1'b1;
                     r_serial_out <= w_tx_next;
                  end
               end
            end
            ST_TX_PARITY: begin
               if (w_bit_end) begin
                  r_state      <= ST_TX_STOP;
                  r_cnt        <= '0;
                  r_phase      <= 1'b0;
                  r_serial_out <= 1'b1;
                  r_is_tx      <= 1'b0;
               end
            end
            ST_TX_STOP: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (!r_phase && r_stop2) r_phase <= 1'b1;
                  else                     r_state <= ST_IDLE;
               end
            end
`ifdef ISO_ERROR_SIGNAL_EN
            ST_ERR_SIG: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (!r_phase) begin
                     r_phase      <= 1'b1;
                     r_serial_out <= 1'b1;
                     r_is_tx      <= 1'b0;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
`endif
            default: begin
               r_state <= ST_IDLE;
            end
         endcase

         // Configuration is captured only at frame start so mid-frame
         // changes on the inputs have no effect.
         if (w_launch) begin
            if (!serialIn) begin
               r_state <= ST_RX_START;
               r_cnt   <= '0;
               r_cpb   <= clocksPerBit;
               r_stop2 <= stopBit2;
               r_odd   <= oddParity;
               r_msb   <= msbFirst;
            end else if (!w_tx_empty) begin
               r_state      <= ST_TX_START;
               r_cnt        <= '0;
               r_cpb        <= clocksPerBit;
               r_stop2      <= stopBit2;
               r_odd        <= oddParity;
               r_msb        <= msbFirst;
               r_shift      <= w_tx_head;
               r_par        <= (^w_tx_head) ^ oddParity;
               r_serial_out <= 1'b0;
               r_is_tx      <= 1'b1;
            end
         end
      end
   end

endmodule
